keypad_scan_debounce: RTL and testbench
=======================================

Name: keypad_scan_debounce

Overview:
Parametrised keypad matrix scanner, the successor to the fixed 4x4 keypad/dot-matrix block. It drives active-low row strobes, samples active-low columns and debounces every key independently. Each debounced press or release is emitted as a coded event on a valid/ready interface, with a live pressed-key map for display logic. It sits between the board keypad pins and game control logic.

Parameters:
ROWS, 4, number of keypad rows (2..8)
COLS, 4, number of keypad columns (2..8)
SCAN_DWELL, 100, clock cycles each row is strobed before sampling (>=2)
DEBOUNCE, 4, consecutive frames a key must disagree with its stable state before it flips (1..15)
KEY_W, 4, width of key code; must satisfy 2^KEY_W >= ROWS*COLS

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
keypadCol  in  COLS  column sense lines, active-low; column c is bit [COLS-1-c]
keypadRow  out  ROWS  row strobe, one-hot active-low; row r is bit [ROWS-1-r]
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_code  out  KEY_W  key index r*COLS+c
evt_press  out  1  1 = press, 0 = release
pressed_map  out  ROWS*COLS  debounced state; bit r*COLS+c = 1 means held
any_down  out  1  OR of pressed_map
overflow  out  1  sticky: an event was dropped
ovf_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (async, active-high) values: keypadRow = row 0 active (MSB low, rest high), dwell counter 0, row index 0, all debounce counters 0, pressed_map 0, any_down 0, evt_valid 0, evt_code 0, evt_press 0, overflow 0.
- Reset asserted mid-operation aborts any scan or pending event immediately. No event is produced for keys held across reset. Such keys generate a press once they are debounced after reset.
- Scan: the dwell counter counts 0..SCAN_DWELL-1.
  - At count SCAN_DWELL-1, keypadCol is sampled for the current row.
  - On the next edge the counter returns to 0 and the strobe advances to row r+1, wrapping ROWS-1 to 0.
  - Frame period = ROWS*SCAN_DWELL cycles.
- Raw state of key (r,c) = ~keypadCol[COLS-1-c] sampled while row r is active.
- Debounce, per key, on each sample of its row:
  - If raw equals the stable state, its counter resets to 0.
  - Otherwise the counter increments, saturating at DEBOUNCE.
  - When the counter reaches DEBOUNCE and that key wins the row's flip slot, the stable bit toggles, the counter clears and an event is generated.
- Flip slot: at most one key flips per row sample. The lowest column index wins. Other eligible keys hold their counter at DEBOUNCE and retry at the next sample of that row, one frame later.
- Latency: pressed_map and any_down update on the edge after the qualifying sample. evt_valid asserts on the same edge.
- Event handshake:
  - A transfer occurs when evt_valid && evt_ready at a rising edge.
  - evt_code and evt_press stay stable while evt_valid is high and not accepted.
  - After a transfer, evt_valid drops unless a new event is generated on the same edge. In that case the new event loads and evt_valid stays high.
  - A new event arriving while evt_valid=1 and evt_ready=0 is dropped and overflow is set. pressed_map still updates.
- overflow clears on ovf_clr. If ovf_clr and a drop occur on the same edge, the set wins.
- Ghosting from multi-key presses is not suppressed; each matrix point is treated independently.
- Counter widths: dwell counter uses clog2(SCAN_DWELL) bits; debounce counters use 4 bits.

Test Plan:
(Bench uses ROWS=4, COLS=4, SCAN_DWELL=4, DEBOUNCE=3, so frame = 16 cycles.)
1. Reset release, no keys pressed -> keypadRow cycles 0111, 1011, 1101, 1110, 0111 with 4 cycles per row; evt_valid stays 0, pressed_map=0.
2. Hold key (1,2) (col bit 1 low while keypadRow=1011) for 3 frames, evt_ready=1 -> one press event with evt_code=6, evt_press=1 on the edge after the 3rd sample; pressed_map[6]=1, any_down=1.
3. Release key 6 for 3 frames -> release event with code 6, evt_press=0; pressed_map=0. Release for only 2 frames then re-press -> no event.
4. Keys (0,0) and (0,3) pressed simultaneously -> press for code 0 in frame 3, press for code 3 one frame later; both bits set in pressed_map.
5. evt_ready=0 while two events occur -> first event held stable; second dropped, overflow=1 and pressed_map reflects both keys; pulse ovf_clr -> overflow=0.
6. Assert reset mid-dwell with evt_valid=1 -> all outputs return to reset values immediately; a key still held re-reports its press after 3 frames.

Source files
------------

// File: rtl/keypad_scan_debounce_if.sv
// rtl/keypad_scan_debounce_if.sv - key event valid/ready channel
interface keypad_scan_debounce_if #(
   parameter int KEY_W = 4
);
   logic             evt_valid;
   logic             evt_ready;
   logic [KEY_W-1:0] evt_code;
   logic             evt_press;

   modport master (output evt_valid, output evt_code, output evt_press, input evt_ready);
   modport slave  (input evt_valid, input evt_code, input evt_press, output evt_ready);
endinterface

// File: rtl/keypad_scan_debounce.sv
// rtl/keypad_scan_debounce.sv - keypad matrix scanner with per-key debounce
// Strobes rows active-low, debounces each key, and reports flips as coded events.
module keypad_scan_debounce #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DWELL = 100,
   parameter int DEBOUNCE   = 4,
   parameter int KEY_W      = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [COLS-1:0]        keypadCol,
   output logic [ROWS-1:0]        keypadRow,
   keypad_scan_debounce_if.master evt,
   output logic [ROWS*COLS-1:0]   pressed_map,
   output logic                   any_down,
   output logic                   overflow,
   input  logic                   ovf_clr
);
   localparam int N    = ROWS * COLS;
   localparam int DW_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int IW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [3:0] DB = 4'(DEBOUNCE);

   logic [DW_W-1:0]  r_dwell;
   logic [RW-1:0]    r_row;
   logic [3:0]       r_cnt [N];
   logic [N-1:0]     r_map;
   logic             r_valid;
   logic [KEY_W-1:0] r_code;
   logic             r_press;
   logic             r_ovf;

   logic [3:0]       w_cnt_nxt [N];
   logic [N-1:0]     w_map_nxt;
   logic             w_sample;
   logic             w_flip;
   logic [IW-1:0]    w_flip_idx;
   logic             w_flip_press;
   logic [IW-1:0]    w_idx;
   logic             w_raw;
   logic [3:0]       w_inc;
   logic             w_drop;
   logic [ROWS-1:0]  w_row;

   assign w_sample = (r_dwell == DW_W'(SCAN_DWELL - 1));
   assign w_drop   = w_flip && r_valid && !evt.evt_ready;

   always_comb begin
      w_row = '1;
      for (int r = 0; r < ROWS; r++) begin
         if (r_row == RW'(r)) w_row[ROWS-1-r] = 1'b0;
      end
   end

   // Lowest column that reaches DEBOUNCE takes the single flip slot of this row sample.
   always_comb begin
      w_cnt_nxt    = r_cnt;
      w_map_nxt    = r_map;
      w_flip       = 1'b0;
      w_flip_idx   = '0;
      w_flip_press = 1'b0;
      w_idx        = '0;
      w_raw        = 1'b0;
      w_inc        = '0;
      if (w_sample) begin
         for (int c = 0; c < COLS; c++) begin
            w_idx = IW'(int'(r_row) * COLS + c);
            w_raw = ~keypadCol[COLS-1-c];
            if (w_raw == r_map[w_idx]) begin
               w_cnt_nxt[w_idx] = 4'd0;
            end else begin
               w_inc = (r_cnt[w_idx] >= DB) ? DB : r_cnt[w_idx] + 4'd1;
               if (w_inc == DB && !w_flip) begin
                  w_flip           = 1'b1;
                  w_flip_idx       = w_idx;
                  w_flip_press     = w_raw;
                  w_map_nxt[w_idx] = w_raw;
                  w_cnt_nxt[w_idx] = 4'd0;
               end else begin
                  w_cnt_nxt[w_idx] = w_inc;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dwell <= '0;
         r_row   <= '0;
         for (int i = 0; i < N; i++) r_cnt[i] <= 4'd0;
         r_map   <= '0;
         r_valid <= 1'b0;
         r_code  <= '0;
         r_press <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_sample) begin
            r_dwell <= '0;
            r_row   <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
         end else begin
            r_dwell <= r_dwell + 1'b1;
         end
         r_cnt <= w_cnt_nxt;
         r_map <= w_map_nxt;
         // A fresh event may load on the same edge the previous one is taken.
         if (w_flip && (!r_valid || evt.evt_ready)) begin
            r_valid <= 1'b1;
            r_code  <= KEY_W'(w_flip_idx);
            r_press <= w_flip_press;
         end else if (r_valid && evt.evt_ready) begin
            r_valid <= 1'b0;
         end
         if (w_drop)       r_ovf <= 1'b1;
         else if (ovf_clr) r_ovf <= 1'b0;
      end
   end

   assign keypadRow     = w_row;
   assign pressed_map   = r_map;
   assign any_down      = |r_map;
   assign overflow      = r_ovf;
   assign evt.evt_valid = r_valid;
   assign evt.evt_code  = r_code;
   assign evt.evt_press = r_press;
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb/tb_keypad_scan_debounce.sv - scoreboard bench for keypad_scan_debounce
module tb_keypad_scan_debounce;
   localparam int R = 4, C = 4, DW = 4, DB = 3, N = 16, FR = R * DW;

   typedef struct packed {
      logic [3:0] code;
      logic       press;
   } ev_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [C-1:0]  keypadCol;
   logic [R-1:0]  keypadRow;
   logic [N-1:0]  pressed_map;
   logic          any_down;
   logic          overflow;
   logic          ovf_clr = 1'b0;
   logic [N-1:0]  phys = '0;

   keypad_scan_debounce_if #(.KEY_W(4)) evt_if ();

   keypad_scan_debounce #(
      .ROWS(R), .COLS(C), .SCAN_DWELL(DW), .DEBOUNCE(DB), .KEY_W(4)
   ) dut (
      .clk(clk), .reset(reset), .keypadCol(keypadCol), .keypadRow(keypadRow),
      .evt(evt_if), .pressed_map(pressed_map), .any_down(any_down),
      .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   // Physical keypad: a held key pulls its column low while its row is strobed.
   always_comb begin
      keypadCol = '1;
      for (int r = 0; r < R; r++)
         if (!keypadRow[R-1-r])
            for (int c = 0; c < C; c++)
               if (phys[r*C+c]) keypadCol[C-1-c] = 1'b0;
   end

   int n_checks = 0, n_fail = 0, n_events = 0;
   ev_t q[$];
   ev_t ev_log[$];

   int          k;
   logic [N-1:0] m_map;
   int          m_run [N];
   logic        m_valid, m_ovf, m_flip, m_drop;
   ev_t         m_ev;
   int          m_row, m_key;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      k = 0;
      m_map = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_valid = 1'b0;
      m_ovf = 1'b0;
      q.delete();
   endfunction

   initial model_reset();

   // Reference: frame timing from the cycle count, per-key disagreement run lengths.
   always @(posedge clk) begin
      if (reset) begin
         model_reset();
      end else begin
         m_flip = 1'b0;
         if (k % DW == DW - 1) begin
            m_row = (k / DW) % R;
            for (int c = 0; c < C; c++) begin
               m_key = m_row * C + c;
               if (phys[m_key] == m_map[m_key]) begin
                  m_run[m_key] = 0;
               end else begin
                  m_run[m_key] = m_run[m_key] + 1;
                  if (m_run[m_key] >= DB && !m_flip) begin
                     m_flip = 1'b1;
                     m_map[m_key] = phys[m_key];
                     m_run[m_key] = 0;
                     m_ev.code = 4'(m_key);
                     m_ev.press = phys[m_key];
                  end else if (m_run[m_key] >= DB) begin
                     m_run[m_key] = DB;
                  end
               end
            end
         end
         m_drop = m_flip && m_valid && !evt_if.evt_ready;
         if (m_flip) begin
            if (!m_valid || evt_if.evt_ready) begin
               q.push_back(m_ev);
               m_valid = 1'b1;
            end
         end else if (m_valid && evt_if.evt_ready) begin
            m_valid = 1'b0;
         end
         if (m_drop)       m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
         k++;
      end
   end

   logic [R-1:0] exp_row;
   always @(negedge clk) begin
      if (!reset) begin
         exp_row = '1;
         exp_row[R-1-((k / DW) % R)] = 1'b0;
         check("keypadRow", 32'(keypadRow), 32'(exp_row));
         check("pressed_map", 32'(pressed_map), 32'(m_map));
         check("any_down", 32'(any_down), 32'(|m_map));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("evt_valid", 32'(evt_if.evt_valid), 32'(m_valid));
         if (m_valid && evt_if.evt_valid) begin
            if (q.size() == 0) begin
               check("evt_queue_empty", 32'(q.size()), 32'd1);
            end else begin
               check("evt_code", 32'(evt_if.evt_code), 32'(q[0].code));
               check("evt_press", 32'(evt_if.evt_press), 32'(q[0].press));
               if (evt_if.evt_ready) begin
                  ev_log.push_back(q.pop_front());
                  n_events++;
               end
            end
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   int base;

   initial begin
      evt_if.evt_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_row", 32'(keypadRow), 32'h7);
      check("rst_valid", 32'(evt_if.evt_valid), 32'd0);
      check("rst_map", 32'(pressed_map), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      #1 reset = 1'b0;

      // Idle scan
      cyc(2 * FR);
      check("idle_events", 32'(n_events), 32'd0);

      // Press and release key 6
      base = n_events;
      phys[6] = 1'b1;
      cyc(4 * FR);
      check("press6_events", 32'(n_events - base), 32'd1);
      check("press6_log", 32'(ev_log[$]), 32'({4'd6, 1'b1}));
      check("press6_map", 32'(pressed_map), 32'h0040);
      check("press6_any", 32'(any_down), 32'd1);
      base = n_events;
      phys[6] = 1'b0;
      cyc(4 * FR);
      check("rel6_events", 32'(n_events - base), 32'd1);
      check("rel6_log", 32'(ev_log[$]), 32'({4'd6, 1'b0}));
      check("rel6_map", 32'(pressed_map), 32'h0000);

      // Short release is filtered
      phys[6] = 1'b1;
      cyc(4 * FR);
      base = n_events;
      phys[6] = 1'b0;
      cyc(2 * FR);
      phys[6] = 1'b1;
      cyc(4 * FR);
      check("short_rel_events", 32'(n_events - base), 32'd0);
      check("short_rel_map", 32'(pressed_map), 32'h0040);
      phys[6] = 1'b0;
      cyc(4 * FR);

      // Two keys in one row: lowest column first, other one frame later
      base = n_events;
      phys[0] = 1'b1;
      phys[3] = 1'b1;
      cyc(5 * FR);
      check("row_pair_events", 32'(n_events - base), 32'd2);
      check("row_pair_first", 32'(ev_log[$-1]), 32'({4'd0, 1'b1}));
      check("row_pair_second", 32'(ev_log[$]), 32'({4'd3, 1'b1}));
      check("row_pair_map", 32'(pressed_map), 32'h0009);
      phys = '0;
      cyc(5 * FR);

      // Back-pressure: second event dropped
      evt_if.evt_ready = 1'b0;
      phys[0] = 1'b1;
      phys[5] = 1'b1;
      cyc(5 * FR);
      check("bp_ovf", 32'(overflow), 32'd1);
      check("bp_valid", 32'(evt_if.evt_valid), 32'd1);
      check("bp_map", 32'(pressed_map), 32'h0021);
      ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      evt_if.evt_ready = 1'b1;
      cyc(2);
      phys = '0;
      cyc(5 * FR);

      // Reset while an event is pending
      evt_if.evt_ready = 1'b0;
      phys[10] = 1'b1;
      cyc(4 * FR + 5);
      check("pre_rst_valid", 32'(evt_if.evt_valid), 32'd1);
      reset = 1'b1;
      model_reset();
      #1;
      check("mid_rst_valid", 32'(evt_if.evt_valid), 32'd0);
      check("mid_rst_map", 32'(pressed_map), 32'd0);
      check("mid_rst_any", 32'(any_down), 32'd0);
      check("mid_rst_row", 32'(keypadRow), 32'h7);
      check("mid_rst_code", 32'(evt_if.evt_code), 32'd0);
      cyc(2);
      reset = 1'b0;
      evt_if.evt_ready = 1'b1;
      base = n_events;
      cyc(4 * FR);
      check("post_rst_events", 32'(n_events - base), 32'd1);
      check("post_rst_log", 32'(ev_log[$]), 32'({4'd10, 1'b1}));
      check("post_rst_map", 32'(pressed_map), 32'h0400);

      // Random traffic
      for (int i = 0; i < 150; i++) begin
         phys[$urandom_range(0, N-1)] ^= 1'b1;
         evt_if.evt_ready = ($urandom_range(0, 3) != 0);
         ovf_clr = ($urandom_range(0, 7) == 0);
         cyc($urandom_range(1, 40));
      end
      ovf_clr = 1'b0;
      evt_if.evt_ready = 1'b1;
      phys = '0;
      cyc(6 * FR);
      check("final_valid", 32'(evt_if.evt_valid), 32'd0);
      check("final_map", 32'(pressed_map), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
